// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_sb                                                      |
// | Brief    : Multi-port register file with write bypass and a per-register   |
// |            pending-write scoreboard (alloc / retire / flush).              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_WR-1:0]            wr_retire,
  input  logic                         alloc_valid,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  output logic                         alloc_ready,
  input  logic                         flush,
  output logic                         pend_any
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;
  localparam int c_DEC_W = $clog2(NUM_WR + 1);
  // Wide enough for cnt+1 and for a full-port retirement count without overflow
  localparam int c_EW    = ((CNT_WIDTH > c_DEC_W) ? CNT_WIDTH : c_DEC_W) + 1;
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] r_mem     [c_DEPTH];
  logic [CNT_WIDTH-1:0]  r_cnt     [c_DEPTH];
  logic [c_EW-1:0]       w_dec     [c_DEPTH];
  logic [c_EW-1:0]       w_sum     [c_DEPTH];
  logic [CNT_WIDTH-1:0]  w_cnt_nxt [c_DEPTH];
  logic                  w_fire;

  assign alloc_ready = (alloc_addr == '0) || (r_cnt[alloc_addr] != c_CNT_MAX);
  assign w_fire      = alloc_valid && alloc_ready;

  always_comb begin
    for (int r = 0; r < c_DEPTH; r++) begin
      w_dec[r] = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_retire[j] &&
            wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))
          w_dec[r] = w_dec[r] + c_EW'(1);
      end
    end
  end

  // Retirements beyond the outstanding count saturate at zero
  always_comb begin
    for (int r = 0; r < c_DEPTH; r++) begin
      w_sum[r] = {{(c_EW-CNT_WIDTH){1'b0}}, r_cnt[r]} +
                 {{(c_EW-1){1'b0}}, (w_fire && alloc_addr == ADDR_WIDTH'(r))};
      w_cnt_nxt[r] = '0;
      if (!flush && r != 0 && w_sum[r] > w_dec[r])
        w_cnt_nxt[r] = CNT_WIDTH'(w_sum[r] - w_dec[r]);
    end
  end

  // Later ports overwrite earlier ones, giving the highest index priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < c_DEPTH; r++) r_mem[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0)
          r_mem[wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < c_DEPTH; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < c_DEPTH; r++) r_cnt[r] <= w_cnt_nxt[r];
    end
  end

  always_comb begin
    pend_any = 1'b0;
    for (int r = 0; r < c_DEPTH; r++) pend_any = pend_any | (r_cnt[r] != '0);
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;

    assign w_addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      w_data = r_mem[w_addr];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == w_addr)
          w_data = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
      if (w_addr == '0) w_data = '0;
    end

    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_data;
    // A retiring write this cycle is bypassed, so it is not a hazard
    assign rd_busy[i] = (w_addr != '0) &&
                        ({{(c_EW-CNT_WIDTH){1'b0}}, r_cnt[w_addr]} > w_dec[w_addr]);
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_regfile_sb                                                   |
// | Brief    : Directed vector bench for regfile_sb (default parameters).      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_regfile_sb;

  typedef struct packed {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  ret;
    logic        av;
    logic [4:0]  aa;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic        ar;
    logic        pa;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  wr_retire;
  logic        alloc_valid;
  logic [4:0]  alloc_addr;
  logic        alloc_ready;
  logic        flush;
  logic        pend_any;

  int n_chk  = 0;
  int n_pass = 0;

  vec_t tbl [25];

  regfile_sb dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_retire   (wr_retire),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .alloc_ready (alloc_ready),
    .flush       (flush),
    .pend_any    (pend_any)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0, logic [4:0] wa1, logic [31:0] wd1,
    logic [1:0] ret, logic av, logic [4:0] aa, logic fl, logic [4:0] ra0, logic [4:0] ra1,
    logic [31:0] d0, logic [31:0] d1, logic [1:0] busy, logic ar, logic pa);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ret = ret; v.av = av; v.aa = aa; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
    v.d0 = d0; v.d1 = d1; v.busy = busy; v.ar = ar; v.pa = pa;
    return v;
  endfunction

  task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
  endtask

  task automatic idle_inputs();
    wr_en = 2'b00; wr_addr = '0; wr_data = '0; wr_retire = 2'b00;
    alloc_valid = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  initial begin
    //            we    wa0 wd0           wa1 wd1    ret   av  aa fl ra0 ra1 d0            d1            busy  ar pa
    tbl[0]  = mk(2'b01, 5, 32'hDEADBEEF, 0, 32'h0,  2'b00, 0, 0, 0, 5, 0, 32'hDEADBEEF, 32'h0,        2'b00, 1, 0);
    tbl[1]  = mk(2'b00, 0, 32'h0,        0, 32'h0,  2'b00, 0, 0, 0, 5, 7, 32'hDEADBEEF, 32'h0,        2'b00, 1, 0);
    tbl[2]  = mk(2'b11, 7, 32'h11,       7, 32'h22, 2'b00, 0, 0, 0, 7, 5, 32'h22,       32'hDEADBEEF, 2'b00, 1, 0);
    tbl[3]  = mk(2'b00, 0, 32'h0,        0, 32'h0,  2'b00, 0, 0, 0, 7, 5, 32'h22,       32'hDEADBEEF, 2'b00, 1, 0);
    tbl[4]  = mk(2'b00, 0, 32'h0,        0, 32'h0,  2'b00, 1, 3, 0, 3, 7, 32'h0,        32'h22,       2'b00, 1, 0);
    tbl[5]  = mk(2'b00, 0, 32'h0,        0, 32'h0,  2'b00, 1, 3, 0, 3, 7, 32'h0,        32'h22,       2'b01, 1, 1);
    tbl[6]  = mk(2'b00, 0, 32'h0,        0, 32'h0,  2'b00, 1, 3, 0, 3, 7, 32'h0,        32'h22,       2'b01, 1, 1);
    tbl[7]  = mk(2'b00, 0, 32'h0,        0, 32'h0,  2'b00, 0, 3, 0, 3, 3, 32'h0,        32'h0,        2'b11, 0, 1);
    tbl[8]  = mk(2'b00, 0, 32'h0,        0, 32'h0,  2'b00, 0, 4, 0, 3, 7, 32'h0,        32'h22,       2'b01, 1, 1);
    tbl[9]  = mk(2'b10, 0, 32'h0,        3, 32'h33, 2'b10, 1, 3, 0, 3, 7, 32'h33,       32'h22,       2'b01, 0, 1);
    tbl[10] = mk(2'b00, 0, 32'h0,        0, 32'h0,  2'b00, 0, 3, 0, 3, 7, 32'h33,       32'h22,       2'b01, 1, 1);
    tbl[11] = mk(2'b11, 3, 32'h44,       3, 32'h45, 2'b11, 0, 0, 0, 3, 7, 32'h45,       32'h22,       2'b00, 1, 1);
    tbl[12] = mk(2'b00, 0, 32'h0,        0, 32'h0,  2'b00, 0, 0, 0, 3, 7, 32'h45,       32'h22,       2'b00, 1, 0);
    tbl[13] = mk(2'b01, 3, 32'h46,       0, 32'h0,  2'b01, 0, 0, 0, 3, 7, 32'h46,       32'h22,       2'b00, 1, 0);
    tbl[14] = mk(2'b00, 0, 32'h0,        0, 32'h0,  2'b00, 1, 3, 0, 3, 7, 32'h46,       32'h22,       2'b00, 1, 0);
    tbl[15] = mk(2'b00, 0, 32'h0,        0, 32'h0,  2'b00, 1, 9, 0, 3, 9, 32'h46,       32'h0,        2'b01, 1, 1);
    tbl[16] = mk(2'b01, 9, 32'h90,       0, 32'h0,  2'b01, 1, 9, 0, 9, 3, 32'h90,       32'h46,       2'b10, 1, 1);
    tbl[17] = mk(2'b00, 0, 32'h0,        0, 32'h0,  2'b00, 0, 0, 0, 9, 3, 32'h90,       32'h46,       2'b11, 1, 1);
    tbl[18] = mk(2'b11, 9, 32'h91,       3, 32'h47, 2'b11, 0, 0, 0, 9, 3, 32'h91,       32'h47,       2'b00, 1, 1);
    tbl[19] = mk(2'b01, 0, 32'h55,       0, 32'h0,  2'b00, 1, 0, 0, 0, 3, 32'h0,        32'h47,       2'b00, 1, 0);
    tbl[20] = mk(2'b00, 0, 32'h0,        0, 32'h0,  2'b00, 0, 0, 0, 0, 3, 32'h0,        32'h47,       2'b00, 1, 0);
    tbl[21] = mk(2'b00, 0, 32'h0,        0, 32'h0,  2'b00, 1, 2, 0, 2, 6, 32'h0,        32'h0,        2'b00, 1, 0);
    tbl[22] = mk(2'b00, 0, 32'h0,        0, 32'h0,  2'b00, 1, 6, 0, 2, 6, 32'h0,        32'h0,        2'b01, 1, 1);
    tbl[23] = mk(2'b01, 2, 32'h99,       0, 32'h0,  2'b00, 0, 0, 1, 2, 6, 32'h99,       32'h0,        2'b11, 1, 1);
    tbl[24] = mk(2'b00, 0, 32'h0,        0, 32'h0,  2'b00, 0, 0, 0, 2, 6, 32'h99,       32'h0,        2'b00, 1, 0);

    rst = 1'b0;
    idle_inputs();
    rd_addr = {5'd7, 5'd5};
    #1;
    chk("reset_rd_data0", -1, rd_data[31:0], 32'h0);
    chk("reset_rd_busy", -1, {30'd0, rd_busy}, 32'h0);
    chk("reset_alloc_ready", -1, {31'd0, alloc_ready}, 32'h1);
    chk("reset_pend_any", -1, {31'd0, pend_any}, 32'h0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    for (int s = 0; s < 25; s++) begin
      wr_en       = tbl[s].we;
      wr_addr     = {tbl[s].wa1, tbl[s].wa0};
      wr_data     = {tbl[s].wd1, tbl[s].wd0};
      wr_retire   = tbl[s].ret;
      alloc_valid = tbl[s].av;
      alloc_addr  = tbl[s].aa;
      flush       = tbl[s].fl;
      rd_addr     = {tbl[s].ra1, tbl[s].ra0};
      #1;
      chk("rd_data0", s, rd_data[31:0], tbl[s].d0);
      chk("rd_data1", s, rd_data[63:32], tbl[s].d1);
      chk("rd_busy", s, {30'd0, rd_busy}, {30'd0, tbl[s].busy});
      chk("alloc_ready", s, {31'd0, alloc_ready}, {31'd0, tbl[s].ar});
      chk("pend_any", s, {31'd0, pend_any}, {31'd0, tbl[s].pa});
      @(posedge clk); #1;
    end

    // Fill x3 to the maximum, then pulse reset asynchronously mid-cycle
    idle_inputs();
    rd_addr = {5'd3, 5'd2};
    alloc_valid = 1'b1;
    alloc_addr  = 5'd3;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    alloc_valid = 1'b0;
    #1;
    chk("full_alloc_ready", 100, {31'd0, alloc_ready}, 32'h0);
    chk("full_rd_busy", 100, {30'd0, rd_busy}, 32'h2);
    chk("pre_rst_rd_data0", 100, rd_data[31:0], 32'h99);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_alloc_ready", 101, {31'd0, alloc_ready}, 32'h1);
    chk("mid_rst_rd_busy", 101, {30'd0, rd_busy}, 32'h0);
    chk("mid_rst_pend_any", 101, {31'd0, pend_any}, 32'h0);
    chk("mid_rst_rd_data0", 101, rd_data[31:0], 32'h0);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    rd_addr = {5'd7, 5'd5};
    #1;
    chk("post_rst_rd_data0", 102, rd_data[31:0], 32'h0);
    chk("post_rst_rd_data1", 102, rd_data[63:32], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
